bus_traffic_generator: RTL and testbench

Synthesizable bus initiator that drives the CPU-side request/ready bus with a self-checking write-then-readback pattern. It sits in place of a CPU master on SoC test builds and in testbenches, exercising memories and peripherals with protocol-correct traffic. It reports pass/fail and an error count. The protocol rules are the ones the bus monitors check: request held until ready, one request per ready, and no cancellation.

---
 rtl/bus_traffic_generator.sv | 152 +++++++++++++++
 tb/tb_bus_traffic_generator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_traffic_generator.sv
// Bus initiator: writes an LFSR pattern to WORDS consecutive words, reads it back and
// counts mismatches. Holds each request until ready; the only cancellation is a timeout.
module bus_traffic_generator #(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned WORDS   = 256,
  parameter logic [31:0] SEED    = 32'hACE1_2345,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [15:0] o_error_count,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata
);

  localparam logic [31:0] SeedEff = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] Mask    = 32'h8020_0003;
  localparam logic [31:0] WaitMax = 32'(TIMEOUT - 1);
  localparam logic [31:0] NWords  = 32'(WORDS);

  typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

  state_e      state_q, state_d;
  logic        write_ph_q, write_ph_d;
  logic [15:0] index_q, index_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] wait_q, wait_d;
  logic [15:0] err_q, err_d;
  logic        timeout_q, timeout_d;
  logic        pass_q, pass_d;
  logic        busy_q, done_q, req_q, rw_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] lfsr_next;

  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? Mask : 32'h0);

  always_comb begin
    state_d    = state_q;
    write_ph_d = write_ph_q;
    index_d    = index_q;
    lfsr_d     = lfsr_q;
    wait_d     = wait_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d    = StReq;
          write_ph_d = 1'b1;
          index_d    = 16'd0;
          lfsr_d     = SeedEff;
          wait_d     = 32'd0;
          err_d      = 16'd0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
        end
      end
      StReq: begin
        if (i_bus_ready) begin
          if (!write_ph_q && (i_bus_rdata != lfsr_q) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
          lfsr_d  = lfsr_next;
          index_d = index_q + 16'd1;
          state_d = StGap;
        end else if (wait_q >= WaitMax) begin
          // Fault exit: the only case where a request is withdrawn without ready.
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      StGap: begin
        wait_d = 32'd0;
        if ({16'd0, index_q} < NWords) begin
          state_d = StReq;
        end else if (write_ph_q) begin
          write_ph_d = 1'b0;
          index_d    = 16'd0;
          lfsr_d     = SeedEff;
          state_d    = StReq;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StDone && state_q != StDone) begin
      pass_d = (err_d == 16'd0) && !timeout_d;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      write_ph_q <= 1'b0;
      index_q    <= 16'd0;
      lfsr_q     <= SeedEff;
      wait_q     <= 32'd0;
      err_q      <= 16'd0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      write_ph_q <= write_ph_d;
      index_q    <= index_d;
      lfsr_q     <= lfsr_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
      busy_q     <= (state_d == StReq) || (state_d == StGap);
      done_q     <= (state_d == StDone);
      req_q      <= (state_d == StReq);
      // Bus fields only load for REQ cycles, so they cannot move under a held request.
      if (state_d == StReq) begin
        rw_q    <= write_ph_d;
        addr_q  <= BASE + {14'd0, index_d, 2'b00};
        wdata_q <= write_ph_d ? lfsr_d : 32'd0;
      end
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_timeout     = timeout_q;
  assign o_error_count = err_q;
  assign o_bus_rw      = rw_q;
  assign o_bus_request = req_q;
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_traffic_generator.sv
// Directed bench: one generator (WORDS=4, TIMEOUT=8) with a mode-switchable responder,
// and a second generator (SEED=0, WORDS=2) with a zero-wait memory.
module tb_bus_traffic_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Instance A
  logic        busy_a, done_a, pass_a, tout_a, rw_a, req_a, ready_a;
  logic [15:0] err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  // Instance B
  logic        busy_b, done_b, pass_b, tout_b, rw_b, req_b, ready_b;
  logic [15:0] err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  always #5 clk = ~clk;

  bus_traffic_generator #(.BASE(32'h0), .WORDS(4), .SEED(32'hACE1_2345), .TIMEOUT(8)) u_a (
    .i_clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy_a), .o_done(done_a),
    .o_pass(pass_a), .o_timeout(tout_a), .o_error_count(err_a), .o_bus_rw(rw_a),
    .o_bus_request(req_a), .i_bus_ready(ready_a), .o_bus_address(addr_a),
    .o_bus_wdata(wdata_a), .i_bus_rdata(rdata_a)
  );

  bus_traffic_generator #(.BASE(32'h0), .WORDS(2), .SEED(32'h0), .TIMEOUT(8)) u_b (
    .i_clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy_b), .o_done(done_b),
    .o_pass(pass_b), .o_timeout(tout_b), .o_error_count(err_b), .o_bus_rw(rw_b),
    .o_bus_request(req_b), .i_bus_ready(ready_b), .o_bus_address(addr_b),
    .o_bus_wdata(wdata_b), .i_bus_rdata(rdata_b)
  );

  // Responder A modes: 0 zero-wait memory, 1 ready on 3rd request cycle,
  // 2 never ready, 3 zero-wait memory with data bit 5 stuck at 1.
  int          mode = 0;
  int          lat_cnt = 0;
  logic [31:0] mem_a [4];
  logic [31:0] mem_b [2];
  logic [31:0] wlog_b [2];

  assign ready_a = req_a && ((mode == 1) ? (lat_cnt == 2) : (mode != 2));
  assign rdata_a = mem_a[addr_a[3:2]];
  assign ready_b = req_b;
  assign rdata_b = mem_b[addr_b[2]];

  always @(posedge clk) begin
    if (!req_a || ready_a) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
    if (req_a && ready_a && rw_a) mem_a[addr_a[3:2]] <= wdata_a | ((mode == 3) ? 32'h20 : 32'h0);
    if (req_b && ready_b && rw_b) begin
      mem_b[addr_b[2]]  <= wdata_b;
      wlog_b[addr_b[2]] <= wdata_b;
    end
  end

  // Bus monitor on A: stability under request, request length in latency mode, txn log.
  int          txn = 0;
  int          stab_err = 0;
  int          len_err = 0;
  int          run_len = 0;
  logic [31:0] p_addr, p_wdata;
  logic        p_rw;
  logic [31:0] addr_log [8];
  logic [31:0] wd_log [8];
  logic        rw_log [8];

  always @(negedge clk) begin
    if (req_a) begin
      if (run_len > 0 && (addr_a !== p_addr || wdata_a !== p_wdata || rw_a !== p_rw))
        stab_err++;
      run_len++;
      p_addr  = addr_a;
      p_wdata = wdata_a;
      p_rw    = rw_a;
      if (ready_a) begin
        if (txn < 8) begin
          addr_log[txn] = addr_a;
          wd_log[txn]   = wdata_a;
          rw_log[txn]   = rw_a;
        end
        txn++;
      end
    end else begin
      if (run_len != 0 && mode == 1 && run_len != 3) len_err++;
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge and count cycles until o_done (cycle 1 = first after start).
  task automatic run(output int cyc);
    txn = 0; stab_err = 0; len_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int n;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_timeout", 32'(tout_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_req", 32'(req_a), 32'd0);
    check("rst_rw", 32'(rw_a), 32'd0);
    check("rst_addr", addr_a, 32'd0);
    check("rst_wdata", wdata_a, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait memory
    mode = 0;
    txn = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy_a), 32'd1);
    check("start_req", 32'(req_a), 32'd1);
    check("start_rw", 32'(rw_a), 32'd1);
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("zw_done_cycle", 32'(cyc), 32'd17);
    check("zw_pass", 32'(pass_a), 32'd1);
    check("zw_err", 32'(err_a), 32'd0);
    check("zw_busy_at_done", 32'(busy_a), 32'd0);
    check("zw_txn", 32'(txn), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check("zw_waddr", addr_log[i], 32'(4 * i));
      check("zw_raddr", addr_log[i + 4], 32'(4 * i));
      check("zw_wrw", 32'(rw_log[i]), 32'd1);
      check("zw_rrw", 32'(rw_log[i + 4]), 32'd0);
      check("zw_rdata0", wd_log[i + 4], 32'd0);
    end
    check("zw_wdata0", wd_log[0], 32'hACE1_2345);
    check("zw_wdata1", wd_log[1], 32'hD650_91A1);
    check("zw_wdata2", wd_log[2], 32'hEB08_48D3);
    check("zw_wdata3", wd_log[3], 32'hF5A4_246A);
    check("b_wdata0", wlog_b[0], 32'h0000_0001);
    check("b_wdata1", wlog_b[1], 32'h8020_0003);
    check("b_pass", 32'(pass_b), 32'd1);
    @(negedge clk);
    check("done_pulse_len", 32'(done_a), 32'd0);
    check("pass_held", 32'(pass_a), 32'd1);

    // 3-cycle latency responder
    mode = 1;
    run(cyc);
    check("lat_pass", 32'(pass_a), 32'd1);
    check("lat_stable", 32'(stab_err), 32'd0);
    check("lat_req_len", 32'(len_err), 32'd0);
    check("lat_txn", 32'(txn), 32'd8);
    check("lat_done_cycle", 32'(cyc), 32'd33);
    @(negedge clk);

    // Bit 5 stuck at 1: written words 0 and 2 have bit 5 clear
    mode = 3;
    run(cyc);
    check("stuck_err", 32'(err_a), 32'd2);
    check("stuck_pass", 32'(pass_a), 32'd0);
    @(negedge clk);

    // Never ready: timeout after 8 request cycles
    mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (req_a === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("to_req_cycles", 32'(n), 32'd8);
    check("to_done", 32'(done_a), 32'd1);
    check("to_timeout", 32'(tout_a), 32'd1);
    check("to_pass", 32'(pass_a), 32'd0);
    @(negedge clk);
    check("to_sticky", 32'(tout_a), 32'd1);
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("to_cleared", 32'(tout_a), 32'd0);
    n = 1;
    while (done_a !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("to_rerun_pass", 32'(pass_a), 32'd1);
    @(negedge clk);

    // Asynchronous reset while in REQ
    mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rr_in_req", 32'(req_a), 32'd1);
    rst = 1'b1;
    #1;
    check("rr_req_drop", 32'(req_a), 32'd0);
    check("rr_busy_drop", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a === 1'b1) n++;
    end
    check("rr_no_done", 32'(n), 32'd0);
    mode = 0;
    run(cyc);
    check("rr_rerun_cycle", 32'(cyc), 32'd17);
    check("rr_rerun_pass", 32'(pass_a), 32'd1);
    @(negedge clk);

    // Start held high: ignored mid-run, relaunches from IDLE after DONE
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_done_cycle", 32'(cyc), 32'd17);
    @(negedge clk);
    check("hold_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("hold_restart", 32'(busy_a), 32'd1);
    start = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("hold_second_pass", 32'(pass_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
